// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for the MEM stage.
// Accepts a load or store, freezes the pipeline through `ready` for LATENCY
// cycles, commits the store or captures the load result on the edge that
// enters DONE, then releases the pipeline for exactly one cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   MEM_R_EN     load request from MEM stage
//   MEM_W_EN     store request from MEM stage
//   ALU_res      byte address of the request
//   ST_value     store data
//   ready        0 = freeze pipeline, 1 = MEM stage may advance at this edge
//   dataMem_out  registered load result, held until the next load completes
//   rd_valid     one-cycle pulse in DONE when a load completed
//   err          one-cycle pulse in DONE when the request completed with error
module data_mem_responder #(
    parameter int unsigned WORD_LEN   = 32,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned BASE_ADDR  = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic [WORD_LEN-1:0] ALU_res,
    input  logic [WORD_LEN-1:0] ST_value,
    output logic                ready,
    output logic [WORD_LEN-1:0] dataMem_out,
    output logic                rd_valid,
    output logic                err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [WORD_LEN-1:0] BASE     = WORD_LEN'(BASE_ADDR);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_LEN-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0] data_q, data_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [WORD_LEN-1:0] dout_q, dout_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic [WORD_LEN-1:0] mem [DEPTH];

    // Request under decode: the live inputs while idle (needed when LATENCY
    // is 1 and the commit edge is the acceptance edge), the latched copy after.
    logic                eff_rd_c;
    logic                eff_wr_c;
    logic [WORD_LEN-1:0] eff_addr_c;
    logic [WORD_LEN-1:0] eff_data_c;
    logic [WORD_LEN-1:0] diff_c;
    logic [WORD_LEN-1:0] idx_full_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic                dec_err_c;
    logic                commit_c;
    logic                is_load_c;
    logic                is_store_c;
    logic                mem_we_c;

    // Address decode of the effective request
    always_comb begin
        eff_rd_c   = (state_q == S_IDLE) ? MEM_R_EN : rd_q;
        eff_wr_c   = (state_q == S_IDLE) ? MEM_W_EN : wr_q;
        eff_addr_c = (state_q == S_IDLE) ? ALU_res  : addr_q;
        eff_data_c = (state_q == S_IDLE) ? ST_value : data_q;
        diff_c     = eff_addr_c - BASE;
        idx_full_c = diff_c >> 2;
        idx_c      = idx_full_c[DEPTH_LOG2-1:0];
        dec_err_c  = (eff_addr_c[1:0] != 2'b00)
                   | (eff_addr_c < BASE)
                   | (idx_full_c[WORD_LEN-1:DEPTH_LOG2] != '0)
                   | (eff_rd_c & eff_wr_c);
        is_load_c  = eff_rd_c & ~eff_wr_c;
        is_store_c = eff_wr_c & ~eff_rd_c;
    end

    // Next-state, request latch, and completion outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        ready      = 1'b0;
        commit_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = ~(MEM_R_EN | MEM_W_EN);
                if (MEM_R_EN | MEM_W_EN) begin
                    addr_d = ALU_res;
                    data_d = ST_value;
                    rd_d   = MEM_R_EN;
                    wr_d   = MEM_W_EN;
                    cnt_d  = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d  = S_DONE;
                        commit_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pulses are registered on the edge into DONE, so they live only in DONE
        if (commit_c) begin
            err_d = dec_err_c;
            if (is_load_c) begin
                rd_valid_d = 1'b1;
                dout_d     = dec_err_c ? '0 : mem[idx_c];
            end
        end
    end

    // Reset gates the write so a commit can never land while rst is held low
    assign mem_we_c = commit_c & is_store_c & ~dec_err_c & rst;

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[idx_c] <= eff_data_c;
        end
    end

    assign dataMem_out = dout_q;
    assign rd_valid    = rd_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 1, 4) checked
// against a transaction-level memory model kept in the bench.
module tb_data_mem_responder;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst;
    logic        r_en  [NDUT];
    logic        w_en  [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wdata [NDUT];
    logic        rdy   [NDUT];
    logic        rv    [NDUT];
    logic        er    [NDUT];
    logic [31:0] dout  [NDUT];

    int vectors;
    int miscompares;

    // Reference model: word store, known flags, expected held load result
    logic [31:0] mmem    [NDUT][256];
    bit          mknown  [NDUT][256];
    logic [31:0] mdout   [NDUT];
    bit          mdknown [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
            data_mem_responder #(
                .WORD_LEN   (32),
                .DEPTH_LOG2 (8),
                .BASE_ADDR  (1024),
                .LATENCY    (LAT)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .MEM_R_EN    (r_en[g]),
                .MEM_W_EN    (w_en[g]),
                .ALU_res     (addr[g]),
                .ST_value    (wdata[g]),
                .ready       (rdy[g]),
                .dataMem_out (dout[g]),
                .rd_valid    (rv[g]),
                .err         (er[g])
            );
        end
    endgenerate

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
    endfunction

    // One request on DUT d, expectations derived from the addressing rules.
    // Entered and left at posedge+1.
    task automatic run_req(input int d, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] v,
                           input string tag);
        int          stall;
        bit          noisy;
        bit          bad;
        bit          e_rv;
        int          idx;
        bad  = (a[1:0] != 2'b00) || (a < 32'd1024)
            || (((a - 32'd1024) >> 2) >= 32'd256) || (r && w);
        idx  = bad ? 0 : int'((a - 32'd1024) >> 2);
        e_rv = r && !w;
        if (r && !w) begin
            if (bad) begin
                mdout[d]   = 32'h0;
                mdknown[d] = 1'b1;
            end else begin
                mdout[d]   = mmem[d][idx];
                mdknown[d] = mknown[d][idx];
            end
        end
        if (w && !r && !bad) begin
            mmem[d][idx]   = v;
            mknown[d][idx] = 1'b1;
        end

        r_en[d]  = r;
        w_en[d]  = w;
        addr[d]  = a;
        wdata[d] = v;
        stall = 0;
        noisy = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy[d] === 1'b1) break;
            if (rv[d] !== 1'b0 || er[d] !== 1'b0) noisy = 1'b1;
            stall++;
            if (stall > 40) break;
        end

        vectors++;
        if (stall != lat_of(d)) begin
            miscompares++;
            $display("FAIL %s stall: got %0d cycles want %0d", tag, stall, lat_of(d));
        end
        if (stall <= 40) begin
            vectors++;
            if (er[d] !== bad) begin
                miscompares++;
                $display("FAIL %s err: got %b want %b", tag, er[d], bad);
            end
            vectors++;
            if (rv[d] !== e_rv) begin
                miscompares++;
                $display("FAIL %s rd_valid: got %b want %b", tag, rv[d], e_rv);
            end
            vectors++;
            if (noisy !== 1'b0) begin
                miscompares++;
                $display("FAIL %s pulse_outside_done: got %b want 0", tag, noisy);
            end
            if (mdknown[d]) begin
                vectors++;
                if (dout[d] !== mdout[d]) begin
                    miscompares++;
                    $display("FAIL %s dataMem_out: got %h want %h", tag, dout[d], mdout[d]);
                end
            end
        end
        @(posedge clk);
        #1;
        r_en[d] = 1'b0;
        w_en[d] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (dout[d] !== 32'h0 || rv[d] !== 1'b0 || er[d] !== 1'b0 || rdy[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got dout=%h rv=%b err=%b ready=%b want 0/0/0/1",
                         d, dout[d], rv[d], er[d], rdy[d]);
            end
            mdout[d]   = 32'h0;
            mdknown[d] = 1'b1;
        end
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_store_load();
        run_req(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "l2_store");
        run_req(0, 1'b1, 1'b0, 32'd1024, 32'h0, "l2_load");
    endtask

    task automatic test_back_to_back();
        run_req(1, 1'b0, 1'b1, 32'd1028, 32'h11, "l1_store_a");
        run_req(1, 1'b0, 1'b1, 32'd1032, 32'h22, "l1_store_b");
        run_req(1, 1'b1, 1'b0, 32'd1028, 32'h0, "l1_load_a");
        run_req(1, 1'b1, 1'b0, 32'd1032, 32'h0, "l1_load_b");
    endtask

    task automatic test_errors();
        run_req(0, 1'b1, 1'b0, 32'd1026, 32'h0, "misaligned_load");
        run_req(0, 1'b0, 1'b1, 32'd2048, 32'h12345678, "oor_store");
        run_req(0, 1'b1, 1'b0, 32'd1024, 32'h0, "load_after_oor");
        run_req(0, 1'b0, 1'b1, 32'd1020, 32'h77, "below_base_store");
        run_req(0, 1'b0, 1'b1, 32'd1024, 32'h5, "store_5");
        run_req(0, 1'b1, 1'b1, 32'd1024, 32'h99, "both_enables");
        run_req(0, 1'b1, 1'b0, 32'd1024, 32'h0, "load_after_both");
        run_req(0, 1'b1, 1'b0, 32'd2044, 32'h0, "last_word_load");
    endtask

    task automatic test_reset_mid_wait();
        run_req(0, 1'b0, 1'b1, 32'd1040, 32'hAAAA, "rmw_store_a");
        run_req(0, 1'b1, 1'b0, 32'd1040, 32'h0, "rmw_load_a");
        r_en[0]  = 1'b0;
        w_en[0]  = 1'b1;
        addr[0]  = 32'd1040;
        wdata[0] = 32'hBBBB;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (dout[d] !== 32'h0 || rv[d] !== 1'b0 || er[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_mid_wait_outputs dut%0d: got dout=%h rv=%b err=%b want 0/0/0",
                         d, dout[d], rv[d], er[d]);
            end
            mdout[d]   = 32'h0;
            mdknown[d] = 1'b1;
        end
        w_en[0] = 1'b0;
        idle_cycles(1);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_wait_idle: got ready=%b want 1", rdy[0]);
        end
        @(posedge clk);
        #1;
        run_req(0, 1'b1, 1'b0, 32'd1040, 32'h0, "rmw_load_after_reset");
    endtask

    task automatic test_latency4();
        run_req(2, 1'b1, 1'b0, 32'd1052, 32'h0, "l4_cold_load");
        @(negedge clk);
        vectors++;
        if (rv[2] !== 1'b0 || er[2] !== 1'b0 || rdy[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL l4_pulse_width: got rv=%b err=%b ready=%b want 0/0/1", rv[2], er[2], rdy[2]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] v;
        int          sel;
        int          op;
        bit          r;
        bit          w;
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 50; n++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7)       a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 255));
                else if (sel == 7) a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 255)) + 32'($urandom_range(1, 3));
                else if (sel == 8) a = 32'($urandom_range(0, 1023));
                else               a = 32'd2048 + 32'($urandom_range(0, 4000));
                op = int'($urandom_range(0, 9));
                r  = (op >= 4);
                w  = (op <= 3) || (op == 9);
                v  = $urandom;
                run_req(d, r, w, a, v, $sformatf("rand_d%0d_n%0d", d, n));
                idle_cycles(int'($urandom_range(0, 2)));
            end
            // Read back a few stored words so random stores are observed
            for (int k = 0; k < 8; k++) begin
                run_req(d, 1'b1, 1'b0, 32'd1024 + 32'd4 * 32'($urandom_range(0, 255)), 32'h0,
                        $sformatf("rand_rb_d%0d_k%0d", d, k));
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            r_en[d]    = 1'b0;
            w_en[d]    = 1'b0;
            addr[d]    = 32'h0;
            wdata[d]   = 32'h0;
            mdout[d]   = 32'h0;
            mdknown[d] = 1'b0;
            for (int i = 0; i < 256; i++) begin
                mmem[d][i]   = 32'h0;
                mknown[d][i] = 1'b0;
            end
        end
        test_reset();
        test_latency4();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
